// File: rtl/channel_est_pkg.sv
// channel_est_pkg: shared widths, FSM states and the tap accumulator step.
// Defining CHANNEL_EST_SAT_EN makes the tap update saturate; otherwise it wraps.
package channel_est_pkg;
    localparam int width = 16;
    localparam int depth = 30;
    localparam int est_channel_bitwidth = 8;
    localparam int est_code_bitwidth = 8;
    localparam int shift_bitwidth = 2;
    localparam int frac_bits = 6;
    localparam int train_len_bitwidth = 16;
    localparam int sym_bitwidth = 3;
    localparam int win_len = depth - 1 + width;
    localparam int err_w = est_code_bitwidth + 1;
    localparam int grad_w = err_w + $clog2(width);
    localparam int acc_w = est_channel_bitwidth + frac_bits;
    localparam logic signed [acc_w:0] acc_max = (acc_w+1)'(2**(acc_w-1) - 1);
    localparam logic signed [acc_w:0] acc_min = (acc_w+1)'(-(2**(acc_w-1)));

    typedef enum logic [1:0] {IDLE, LOAD, TRAIN, HOLD} state_t;

    function automatic logic signed [acc_w-1:0] acc_step(
        input logic signed [acc_w-1:0] acc,
        input logic signed [grad_w-1:0] grad,
        input logic [3:0] gain
    );
`ifdef CHANNEL_EST_SAT_EN
        logic signed [acc_w:0] sum;
        sum = (acc_w+1)'(acc) + (acc_w+1)'(grad >>> gain);
        return sum > acc_max ? acc_w'(acc_max) : sum < acc_min ? acc_w'(acc_min) : sum[acc_w-1:0];
`else
        return acc + acc_w'(grad >>> gain);
`endif
    endfunction
endpackage

// File: rtl/channel_est_grad.sv
// channel_est_grad: sign-data LMS gradient of one tap, reduced across all lanes.
module channel_est_grad
    import channel_est_pkg::*;
(
    input  logic signed [err_w-1:0]        err [width],
    input  logic signed [sym_bitwidth-1:0] sym [width],
    output logic signed [grad_w-1:0]       grad
);
    always_comb begin
        grad = '0;
        for (int i = 0; i < width; i++) begin
            grad = grad + (sym[i][sym_bitwidth-1] ? -grad_w'(err[i]) :
                           (sym[i] != '0) ? grad_w'(err[i]) : grad_w'(0));
        end
    end
endmodule

// File: rtl/channel_estimator.sv
// channel_estimator: adaptive sign-data LMS tap estimator broadcasting one tap set to all lanes.
// CHANNEL_EST_SAT_EN selects saturating instead of wrapping accumulator updates.
module channel_estimator
    import channel_est_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   rstb,
    input  logic                                   start,
    input  logic                                   freeze,
    input  logic [train_len_bitwidth-1:0]          train_len,
    input  logic [3:0]                             gain,
    input  logic signed [est_channel_bitwidth-1:0] init_chan [depth],
    input  logic                                   in_valid,
    input  logic signed [sym_bitwidth-1:0]         symstream [win_len],
    input  logic signed [est_code_bitwidth-1:0]    codes [width],
    input  logic signed [est_code_bitwidth-1:0]    est_code [width],
    input  logic [shift_bitwidth-1:0]              shift_in,
    output logic signed [est_channel_bitwidth-1:0] channel [width][depth],
    output logic [shift_bitwidth-1:0]              shift [width],
    output logic                                   upd_valid,
    output logic                                   busy
);
    state_t state;
    logic s1_v;
    logic signed [err_w-1:0] err_r [width];
    logic signed [sym_bitwidth-1:0] sym_r [win_len];
    logic signed [grad_w-1:0] grad [depth];
    logic signed [acc_w-1:0] acc [depth];
    logic [train_len_bitwidth-1:0] count;
    logic len_hit, go_hold, accept, commit;

    // a beat still in S1 counts toward train_len so no extra beat is issued
    assign len_hit = |train_len &&
        ((train_len_bitwidth+1)'(count) + (train_len_bitwidth+1)'(s1_v) >= (train_len_bitwidth+1)'(train_len));
    assign go_hold = state == TRAIN && (freeze || len_hit);
    assign accept = state == TRAIN && in_valid && !start && !go_hold;
    assign commit = s1_v && !start;

    for (genvar j = 0; j < depth; j++) begin : g_tap
        logic signed [sym_bitwidth-1:0] win [width];
        for (genvar i = 0; i < width; i++) begin : g_win
            assign win[i] = sym_r[i + depth - 1 - j];
        end
        channel_est_grad u_grad (.err(err_r), .sym(win), .grad(grad[j]));
    end

    always_comb begin
        for (int i = 0; i < width; i++)
            for (int j = 0; j < depth; j++)
                channel[i][j] = acc[j][acc_w-1:frac_bits];
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state <= IDLE;
            busy <= 1'b0;
            upd_valid <= 1'b0;
            s1_v <= 1'b0;
            count <= '0;
            for (int j = 0; j < depth; j++) acc[j] <= '0;
            for (int i = 0; i < width; i++) shift[i] <= '0;
        end else begin
            for (int i = 0; i < width; i++) shift[i] <= shift_in;
            s1_v <= accept;
            upd_valid <= commit;
            if (accept) begin
                for (int i = 0; i < width; i++) err_r[i] <= err_w'(codes[i]) - err_w'(est_code[i]);
                sym_r <= symstream;
            end
            if (commit) begin
                count <= count + train_len_bitwidth'(1);
                for (int j = 0; j < depth; j++) acc[j] <= acc_step(acc[j], grad[j], gain);
            end
            if (start) begin
                state <= LOAD;
                busy <= 1'b1;
            end else if (state == LOAD) begin
                state <= TRAIN;
                count <= '0;
                for (int j = 0; j < depth; j++) acc[j] <= {init_chan[j], {frac_bits{1'b0}}};
            end else if (go_hold) begin
                state <= HOLD;
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_channel_estimator.sv
// tb_channel_estimator: directed checks of reset, load, LMS updates, train length, freeze and reset abort.
module tb_channel_estimator;
    import channel_est_pkg::*;

    logic clk = 1'b0;
    logic rstb = 1'b0, start = 1'b0, freeze = 1'b0, in_valid = 1'b0;
    logic [train_len_bitwidth-1:0] train_len = '0;
    logic [3:0] gain = '0;
    logic [shift_bitwidth-1:0] shift_in = '0;
    logic signed [est_channel_bitwidth-1:0] init_chan [depth];
    logic signed [sym_bitwidth-1:0] symstream [win_len];
    logic signed [est_code_bitwidth-1:0] codes [width];
    logic signed [est_code_bitwidth-1:0] est_code [width];
    logic signed [est_channel_bitwidth-1:0] channel [width][depth];
    logic [shift_bitwidth-1:0] shift [width];
    logic upd_valid, busy;
    int n_cmp = 0, n_bad = 0;
    int p, q;

    channel_estimator dut (
        .clk(clk), .rstb(rstb), .start(start), .freeze(freeze), .train_len(train_len),
        .gain(gain), .init_chan(init_chan), .in_valid(in_valid), .symstream(symstream),
        .codes(codes), .est_code(est_code), .shift_in(shift_in), .channel(channel),
        .shift(shift), .upd_valid(upd_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            step();
            pulses += int'(upd_valid);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic set_all(input int c, input int e, input int s, input int mul, input int add);
        for (int i = 0; i < width; i++) begin
            codes[i] = 8'(c);
            est_code[i] = 8'(e);
        end
        for (int k = 0; k < win_len; k++) symstream[k] = 3'(s);
        for (int j = 0; j < depth; j++) init_chan[j] = 8'(j * mul + add);
    endtask

    function automatic int chan_bad(input int mul, input int add);
        int bad = 0;
        for (int i = 0; i < width; i++)
            for (int j = 0; j < depth; j++)
                if (int'(channel[i][j]) != j * mul + add) bad++;
        return bad;
    endfunction

    initial begin
        for (int c = 0; c < 3; c++) begin
            start = 1'($urandom);
            freeze = 1'($urandom);
            in_valid = 1'($urandom);
            gain = 4'($urandom);
            shift_in = 2'($urandom);
            train_len = 16'($urandom);
            for (int i = 0; i < width; i++) begin
                codes[i] = 8'($urandom);
                est_code[i] = 8'($urandom);
            end
            for (int k = 0; k < win_len; k++) symstream[k] = 3'($urandom);
            for (int j = 0; j < depth; j++) init_chan[j] = 8'($urandom);
            step();
        end
        chk("rst_chan", chan_bad(0, 0), 0);
        chk("rst_upd", upd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", dut.state, IDLE);

        rstb = 1'b1; start = 1'b0; freeze = 1'b0; in_valid = 1'b0;
        gain = 0; train_len = 0; shift_in = 2;
        set_all(0, 0, 0, 1, 0);
        do_start();
        chk("load_chan", chan_bad(1, 0), 0);
        chk("load_c29", channel[7][29], 29);
        chk("load_busy", busy, 1);
        chk("load_upd", upd_valid, 0);
        chk("shift", shift[9], 2);
        step();
        chk("idle_upd", upd_valid, 0);

        set_all(1, 0, 1, 1, 0);
        in_valid = 1'b1;
        step();
        chk("lat1_upd", upd_valid, 0);
        step();
        chk("lat2_upd", upd_valid, 1);
        chk("acc5_1beat", dut.acc[5], 5 * 64 + 16);
        step();
        step();
        in_valid = 1'b0;
        step();
        chk("beat4_upd", upd_valid, 1);
        chk("beat4_c10", channel[3][10], 11);
        chk("beat4_chan", chan_bad(1, 1), 0);
        step();
        chk("drain_upd", upd_valid, 0);

        train_len = 4;
        do_start();
        in_valid = 1'b1;
        run(10, p);
        chk("len_pulses", p, 4);
        chk("len_busy", busy, 0);
        chk("len_state", dut.state, HOLD);
        chk("len_chan", chan_bad(1, 1), 0);
        run(5, p);
        chk("hold_pulses", p, 0);
        chk("hold_chan", chan_bad(1, 1), 0);

        train_len = 0;
        in_valid = 1'b0;
        do_start();
        in_valid = 1'b1;
        run(2, p);
        freeze = 1'b1;
        run(1, q);
        p += q;
        freeze = 1'b0;
        in_valid = 1'b0;
        run(2, q);
        chk("frz_pulses", p + q, 2);
        chk("frz_acc1", dut.acc[1], 64 + 32);
        chk("frz_state", dut.state, HOLD);

        set_all(0, 0, 1, 0, 0);
        codes[0] = 3;
        codes[15] = -5;
        symstream[44] = -1;
        symstream[28] = -2;
        symstream[27] = 0;
        gain = 1;
        do_start();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("vec_upd", upd_valid, 1);
        chk("vec_acc0", dut.acc[0], 4);
        chk("vec_acc1", dut.acc[1], -4);
        chk("vec_acc2", dut.acc[2], -3);
        chk("vec_acc3", dut.acc[3], -1);
        chk("vec_acc29", dut.acc[29], -1);

        set_all(1, 0, 1, 1, 0);
        gain = 0;
        do_start();
        in_valid = 1'b1;
        step();
        step();
        rstb = 1'b0;
        step();
        chk("abort_upd", upd_valid, 0);
        chk("abort_acc3", dut.acc[3], 0);
        chk("abort_state", dut.state, IDLE);
        rstb = 1'b1;
        in_valid = 1'b0;
        set_all(1, 0, 1, 2, 0);
        start = 1'b1;
        run(1, p);
        start = 1'b0;
        run(1, q);
        chk("abort_pulses", p + q, 0);
        chk("abort_chan", chan_bad(2, 0), 0);
        chk("abort_busy", busy, 1);

        set_all(127, 0, 1, 0, 127);
        do_start();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("big_upd", upd_valid, 1);
`ifdef CHANNEL_EST_SAT_EN
        chk("big_chan", chan_bad(0, 127), 0);
`else
        chk("big_chan", chan_bad(0, -98), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
